// File: rtl/if_id_register.sv
// IF/ID pipeline boundary: two-entry skid buffer between fetch and decode with
// a valid/ready handshake on both sides and a synchronous flush for redirects.
module if_id_register #(
   parameter int unsigned      XLEN      = 32,
   parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   pc_in,
   input  logic [XLEN-1:0]   instruction_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   pc_out,
   output logic [XLEN-1:0]   pc_plus_4_out,
   output logic [XLEN-1:0]   instruction_out
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]      r_state,      w_state_n;
   logic            r_out_valid,  w_out_valid_n;
   logic            r_in_ready,   w_in_ready_n;
   logic [XLEN-1:0] r_main_pc,    w_main_pc_n;
   logic [XLEN-1:0] r_main_instr, w_main_instr_n;
   logic [XLEN-1:0] r_skid_pc,    w_skid_pc_n;
   logic [XLEN-1:0] r_skid_instr, w_skid_instr_n;
   logic [XLEN-1:0] r_pc_plus_4,  w_pc_plus_4_n;

   logic w_in_fire;
   logic w_out_fire;

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   // Next-state and next-data; flush overrides any same-cycle transfer.
   always_comb begin
      w_state_n      = r_state;
      w_main_pc_n    = r_main_pc;
      w_main_instr_n = r_main_instr;
      w_skid_pc_n    = r_skid_pc;
      w_skid_instr_n = r_skid_instr;

      if (flush) begin
         w_state_n      = S_EMPTY;
         w_main_pc_n    = '0;
         w_main_instr_n = NOP_INSTR;
         w_skid_pc_n    = '0;
         w_skid_instr_n = NOP_INSTR;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  w_state_n      = S_ONE;
                  w_main_pc_n    = pc_in;
                  w_main_instr_n = instruction_in;
               end
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_main_pc_n    = pc_in;
                  w_main_instr_n = instruction_in;
               end else if (w_in_fire) begin
                  w_state_n      = S_TWO;
                  w_skid_pc_n    = pc_in;
                  w_skid_instr_n = instruction_in;
               end else if (w_out_fire) begin
                  // pc is kept so pc_out holds its last value while idle
                  w_state_n      = S_EMPTY;
                  w_main_instr_n = NOP_INSTR;
               end
            end
            S_TWO: begin
               if (w_out_fire) begin
                  w_state_n      = S_ONE;
                  w_main_pc_n    = r_skid_pc;
                  w_main_instr_n = r_skid_instr;
                  w_skid_pc_n    = '0;
                  w_skid_instr_n = NOP_INSTR;
               end
            end
            default: begin
               w_state_n      = S_EMPTY;
               w_main_instr_n = NOP_INSTR;
            end
         endcase
      end

      w_out_valid_n = (w_state_n != S_EMPTY);
      w_in_ready_n  = (w_state_n != S_TWO);
      w_pc_plus_4_n = w_main_pc_n + XLEN'(32'd4);
   end

   // State and data registers; handshake flags are registered copies of state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_EMPTY;
         r_out_valid  <= 1'b0;
         r_in_ready   <= 1'b1;
         r_main_pc    <= '0;
         r_main_instr <= NOP_INSTR;
         r_skid_pc    <= '0;
         r_skid_instr <= NOP_INSTR;
         r_pc_plus_4  <= XLEN'(32'd4);
      end else begin
         r_state      <= w_state_n;
         r_out_valid  <= w_out_valid_n;
         r_in_ready   <= w_in_ready_n;
         r_main_pc    <= w_main_pc_n;
         r_main_instr <= w_main_instr_n;
         r_skid_pc    <= w_skid_pc_n;
         r_skid_instr <= w_skid_instr_n;
         r_pc_plus_4  <= w_pc_plus_4_n;
      end
   end

   assign out_valid       = r_out_valid;
   assign in_ready        = r_in_ready;
   assign pc_out          = r_main_pc;
   assign pc_plus_4_out   = r_pc_plus_4;
   assign instruction_out = r_main_instr;

endmodule

// File: tb/tb_if_id_register.sv
// Randomized and directed bench for if_id_register, checked against a
// queue-based FIFO model of the fetch->decode boundary.
module tb_if_id_register;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_in;
   logic [31:0] instruction_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_out;
   logic [31:0] pc_plus_4_out;
   logic [31:0] instruction_out;

   int total = 0;
   int bad   = 0;

   // Model: entries in flight, oldest first, plus the last presented pc.
   logic [31:0] q_pc[$];
   logic [31:0] q_ins[$];
   logic [31:0] m_pc;

   if_id_register #(.XLEN(32), .NOP_INSTR(32'h00000013)) dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .pc_in           (pc_in),
      .instruction_in  (instruction_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .pc_out          (pc_out),
      .pc_plus_4_out   (pc_plus_4_out),
      .instruction_out (instruction_out)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] e_ins;
      e_ins = (q_pc.size() > 0) ? q_ins[0] : NOP;
      check_val({tag, ":out_valid"}, 32'(out_valid), 32'(q_pc.size() > 0));
      check_val({tag, ":in_ready"},  32'(in_ready),  32'(q_pc.size() < 2));
      check_val({tag, ":pc_out"},    pc_out,         m_pc);
      check_val({tag, ":pc_plus_4"}, pc_plus_4_out,  m_pc + 32'd4);
      check_val({tag, ":instr"},     instruction_out, e_ins);
   endtask

   task automatic model_reset();
      q_pc.delete();
      q_ins.delete();
      m_pc = '0;
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy, input logic fl);
      bit in_fire;
      bit out_fire;
      in_valid       = iv;
      pc_in          = pc;
      instruction_in = ins;
      out_ready      = ordy;
      flush          = fl;
      in_fire  = iv && (q_pc.size() < 2);
      out_fire = ordy && (q_pc.size() > 0);
      @(posedge clk);
      #1;
      if (fl) begin
         q_pc.delete();
         q_ins.delete();
         m_pc = '0;
      end else begin
         if (out_fire) begin
            void'(q_pc.pop_front());
            void'(q_ins.pop_front());
         end
         if (in_fire) begin
            q_pc.push_back(pc);
            q_ins.push_back(ins);
         end
      end
      if (q_pc.size() > 0) m_pc = q_pc[0];
      check_all(tag);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      pc_in = '0; instruction_in = '0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // 1: streaming with decode always ready
      for (int i = 0; i < 3; i++) step("stream", 1'b1, 32'(i * 4), 32'(i * 4), 1'b1, 1'b0);
      step("stream_drain", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      // 2: decode stall fills the skid entry, then drains in order
      step("stall16", 1'b1, 32'd16, 32'd16, 1'b0, 1'b0);
      step("stall20", 1'b1, 32'd20, 32'd20, 1'b0, 1'b0);
      step("stall_hold", 1'b1, 32'd99, 32'd99, 1'b0, 1'b0);
      step("drain16", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      step("drain20", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      step("drain_empty", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      // 3: flush while full discards the held entries and the same-cycle fetch
      step("fill16", 1'b1, 32'd16, 32'd16, 1'b0, 1'b0);
      step("fill20", 1'b1, 32'd20, 32'd20, 1'b0, 1'b0);
      step("flush_two", 1'b1, 32'd24, 32'd24, 1'b1, 1'b1);
      step("after_flush", 1'b1, 32'd444, 32'd444, 1'b0, 1'b0);
      step("after_flush2", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      // 4: asynchronous reset mid-cycle
      step("load112", 1'b1, 32'd112, 32'hABCD0001, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      @(negedge clk);
      reset = 1'b0;
      step("post_reset", 1'b1, 32'd200, 32'd201, 1'b1, 1'b0);

      // 5: pc + 4 wraps at the top of the address space
      step("wrap", 1'b1, 32'hFFFFFFFC, 32'h12345678, 1'b0, 1'b0);
      step("wrap_drain", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

      // 6: multi-cycle flush with fetch still valid
      for (int i = 0; i < 3; i++) step("flush_hold", 1'b1, 32'(600 + i * 4), 32'(i), 1'b1, 1'b1);
      step("flush_release", 1'b1, 32'd700, 32'd701, 1'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_id_register.md
Name: if_id_register

Overview:
- Pipeline boundary between instruction fetch and decode.
- Captures each fetched {pc, instruction} pair and presents it to decode with a valid/ready handshake.
- A 2-entry skid buffer absorbs one decode stall without a combinational ready path back to fetch.
- A flush input discards everything in flight on a taken jump/branch.

Parameters:
- XLEN, 32, width of pc and instruction.
- NOP_INSTR, 32'h00000013, instruction presented when no valid entry is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all held entries; driven by jump_branch_condition.
- in_valid  input  1  fetch presents a valid pc/instruction.
- in_ready  output  1  register can accept an entry this cycle.
- pc_in  input  XLEN  pc of the fetched instruction.
- instruction_in  input  XLEN  fetched instruction word.
- out_valid  output  1  decode-side entry valid.
- out_ready  input  1  decode accepts the entry this cycle.
- pc_out  output  XLEN  pc of the presented instruction.
- pc_plus_4_out  output  XLEN  pc_out + 4.
- instruction_out  output  XLEN  presented instruction; NOP_INSTR when out_valid=0.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state EMPTY, out_valid=0, in_ready=1.
  - pc_out=0, pc_plus_4_out=4, instruction_out=NOP_INSTR.
  - main and skid registers cleared to pc=0, instr=NOP_INSTR.
- Handshake:
  - In-fire = in_valid & in_ready.
  - Out-fire = out_valid & out_ready.
  - in_ready and out_valid are driven only from registered state. No combinational in->out or out_ready->in_ready path.
- States:
  - EMPTY: no entry.
  - ONE: main holds an entry; out_valid=1.
  - TWO: main and skid hold entries; out_valid=1, in_ready=0.
- Transitions, when flush=0:
  - EMPTY: in-fire -> ONE, main<=in. Otherwise stay EMPTY.
  - ONE:
    - in-fire & out-fire -> ONE, main<=in.
    - in-fire only -> TWO, skid<=in.
    - out-fire only -> EMPTY, main<=NOP.
    - neither -> hold.
  - TWO: out-fire -> ONE, main<=skid, skid<=NOP. Otherwise hold. in_valid is ignored.
- Flush:
  - Highest priority. Next state EMPTY; main and skid instr<=NOP_INSTR, pc<=0.
  - A same-cycle in-fire or out-fire is discarded. Fetch has already redirected, so no entry from that cycle is ever presented.
- Ordering: strict FIFO. Entries reach decode in fetch order with no duplication or loss, except on flush.
- Latency: an entry accepted at edge N is presented (out_valid=1) after edge N when the buffer was EMPTY.
- Throughput: with out_ready held high, one entry per cycle.
- pc_plus_4_out = pc_out + 4, modulo 2^XLEN; 32'hFFFFFFFC wraps to 0.
- Outputs with out_valid=0: pc_out holds its last value; instruction_out is forced to NOP_INSTR.
- Reset asserted mid-operation: immediately (asynchronously) returns to reset values regardless of state or flush.
- After reset deasserts, the first edge behaves as EMPTY.
- Simultaneous out-fire and in-fire in TWO cannot occur, since in_ready=0.

Test Plan:
1. Reset, then drive in_valid=1 with pc=0,4,8 (instr=pc) and out_ready=1 -> after each edge, out_valid=1 with pc_out=0,4,8 one cycle behind; pc_plus_4_out=4,8,12; in_ready stays 1.
2. Decode stall: out_ready=0 while feeding pc=16 then 20 -> state TWO, in_ready=0, pc_out=16 held. Raise out_ready -> pc_out=16, then 20, then out_valid=0 with instruction_out=0x00000013.
3. Flush in TWO (entries 16,20) with in_valid=1 pc=24 in the same cycle -> next cycle out_valid=0, in_ready=1, instruction_out=NOP. Entry 24 is never presented; the next fed pc=444 appears next.
4. Async reset pulsed mid-cycle while in ONE with pc_out=112 -> outputs go immediately to out_valid=0, pc_out=0, pc_plus_4_out=4, instruction_out=0x00000013, without waiting for a clock edge.
5. Wrap: feed pc=32'hFFFFFFFC -> pc_plus_4_out=0.
6. Flush held high for 3 cycles with in_valid=1 -> out_valid stays 0 throughout; the first post-flush entry appears one cycle after flush drops.
